// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use, branch, imem-wait and dmem-wait hazards.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned DWAIT_MAX   = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             pc_nwe,
  output logic             nwe_if_id,
  output logic             nwe_id_ex,
  output logic             nwe_ex_mem,
  output logic             nwe_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             trap_redirect
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {StInit, StRun, StDwait, StTrap} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic load_use, dstall, freeze, run_mode;
  logic hold_pc, hold_if, hold_ie, hold_em, hold_mw;
  logic fl_if, fl_ie, fl_em, fl_mw;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign dstall   = mem_req && !dmem_ready;
  // Freeze covers the detecting RUN cycle and every DWAIT cycle without completion.
  assign freeze   = ((state_q == StRun) && dstall) || ((state_q == StDwait) && !dmem_ready);
  assign run_mode = (state_q == StRun) || (state_q == StDwait);

  always_comb begin
    hold_pc       = 1'b0;
    hold_if       = 1'b0;
    hold_ie       = 1'b0;
    hold_em       = 1'b0;
    hold_mw       = 1'b0;
    fl_if         = 1'b0;
    fl_ie         = 1'b0;
    fl_em         = 1'b0;
    fl_mw         = 1'b0;
    trap_redirect = 1'b0;
    if (state_q == StInit) begin
      {hold_pc, hold_if, hold_ie, hold_em, hold_mw} = 5'b11111;
      {fl_if, fl_ie, fl_em, fl_mw}                  = 4'b1111;
    end else if (state_q == StTrap) begin
      {fl_if, fl_ie, fl_em, fl_mw} = 4'b1111;
      trap_redirect                = 1'b1;
    end else if (freeze) begin
      {hold_pc, hold_if, hold_ie, hold_em} = 4'b1111;
      fl_mw                                = 1'b1;
    end else if (run_mode) begin
      if (ex_branch_taken) begin
        fl_if = 1'b1;
        fl_ie = 1'b1;
      end else if (load_use) begin
        hold_pc = 1'b1;
        hold_if = 1'b1;
        fl_ie   = 1'b1;
      end else if (!imem_ready) begin
        hold_pc = 1'b1;
        fl_if   = 1'b1;
      end
    end
  end

  // A flushed register is never also write-enabled.
  assign pc_nwe       = hold_pc;
  assign nwe_if_id    = hold_if | fl_if;
  assign nwe_id_ex    = hold_ie | fl_ie;
  assign nwe_ex_mem   = hold_em | fl_em;
  assign nwe_mem_wb   = hold_mw | fl_mw;
  assign flush_if_id  = fl_if;
  assign flush_id_ex  = fl_ie;
  assign flush_ex_mem = fl_em;
  assign flush_mem_wb = fl_mw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        if (cnt_q == 8'(INIT_CYCLES - 1)) begin
          state_d = StRun;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRun: begin
        if (dstall) begin
          state_d = StDwait;
          cnt_d   = 8'd1;
        end
      end
      StDwait: begin
        cnt_d = cnt_q + 8'd1;
        // Completion wins over a simultaneous timeout.
        if (dmem_ready) begin
          state_d = StRun;
          cnt_d   = 8'd0;
        end else if (cnt_d == 8'(DWAIT_MAX)) begin
          state_d = StTrap;
          cnt_d   = 8'd0;
        end
      end
      StTrap: state_d = StRun;
      default: begin
        state_d = StInit;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StInit;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (run_mode && pc_nwe) stall_cnt_d = stall_cnt_q + 1'b1;
    if ((state_q != StInit) && (fl_if || fl_ie || fl_em || fl_mw)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with DWAIT_MAX=4 so the timeout path is short.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CntW = 32;

  // {trap, pc_nwe, nwe if/ie/em/mw, flush if/ie/em/mw}
  localparam logic [9:0] ExpInit   = 10'b0_1_1111_1111;
  localparam logic [9:0] ExpRun    = 10'b0_0_0000_0000;
  localparam logic [9:0] ExpLoadU  = 10'b0_1_1100_0100;
  localparam logic [9:0] ExpBranch = 10'b0_0_1100_1100;
  localparam logic [9:0] ExpImem   = 10'b0_1_1000_1000;
  localparam logic [9:0] ExpDstall = 10'b0_1_1111_0001;
  localparam logic [9:0] ExpTrap   = 10'b1_0_1111_1111;

  logic clk = 1'b0;
  logic nrst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_mem_read, ex_branch_taken, mem_req, dmem_ready, imem_ready;
  logic pc_nwe, nwe_if_id, nwe_id_ex, nwe_ex_mem, nwe_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, trap_redirect;
`ifdef PIPE_CTRL_PERF_EN
  logic [CntW-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(
    .INIT_CYCLES(2),
    .DWAIT_MAX  (4),
    .CNT_W      (CntW)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .dmem_ready     (dmem_ready),
    .imem_ready     (imem_ready),
    .pc_nwe         (pc_nwe),
    .nwe_if_id      (nwe_if_id),
    .nwe_id_ex      (nwe_id_ex),
    .nwe_ex_mem     (nwe_ex_mem),
    .nwe_mem_wb     (nwe_mem_wb),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .flush_ex_mem   (flush_ex_mem),
    .flush_mem_wb   (flush_mem_wb),
    .trap_redirect  (trap_redirect)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {trap_redirect, pc_nwe, nwe_if_id, nwe_id_ex, nwe_ex_mem, nwe_mem_wb,
            flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic apply_reset();
    set_idle();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    set_idle();
    nrst = 1'b0;
    step();
    checks++;
    if (obs() !== ExpInit) begin
      errors++; $display("FAIL reset_hold got %b want %b", obs(), ExpInit);
    end
    nrst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== ExpInit) begin
        errors++; $display("FAIL init_cycle%0d got %b want %b", i, obs(), ExpInit);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL init_to_run got %b want %b", obs(), ExpRun);
    end
    step();
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd3;
    @(negedge clk);
    checks++;
    if (obs() !== ExpLoadU) begin
      errors++; $display("FAIL load_use_rs2 got %b want %b", obs(), ExpLoadU);
    end
    step();
    set_idle();
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL load_use_release got %b want %b", obs(), ExpRun);
    end
    step();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL load_use_x0 got %b want %b", obs(), ExpRun);
    end
    step();
    ex_rd = 5'd17; id_rs1 = 5'd17; id_rs2 = 5'd2;
    @(negedge clk);
    checks++;
    if (obs() !== ExpLoadU) begin
      errors++; $display("FAIL load_use_rs1 got %b want %b", obs(), ExpLoadU);
    end
    step();
    ex_mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL no_load_match got %b want %b", obs(), ExpRun);
    end
    step();
    set_idle();
  endtask

  task automatic test_branch();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; imem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== ExpBranch) begin
      errors++; $display("FAIL branch_priority got %b want %b", obs(), ExpBranch);
    end
    step();
    set_idle();
    imem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== ExpImem) begin
      errors++; $display("FAIL imem_wait got %b want %b", obs(), ExpImem);
    end
    step();
    set_idle();
  endtask

  task automatic test_dmem_wait();
    apply_reset();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_branch_taken = (i == 1);
      @(negedge clk);
      checks++;
      if (obs() !== ExpDstall) begin
        errors++; $display("FAIL dwait_freeze%0d got %b want %b", i, obs(), ExpDstall);
      end
      step();
    end
    ex_branch_taken = 1'b0;
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL dwait_complete got %b want %b", obs(), ExpRun);
    end
    step();
    set_idle();
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL dwait_after got %b want %b", obs(), ExpRun);
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (perf_stall_cnt !== 32'd3) begin
      errors++; $display("FAIL perf_stall got %0d want 3", perf_stall_cnt);
    end
    checks++;
    if (perf_flush_cnt !== 32'd3) begin
      errors++; $display("FAIL perf_flush got %0d want 3", perf_flush_cnt);
    end
`endif
    step();
  endtask

  task automatic test_timeout();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== ExpDstall) begin
        errors++; $display("FAIL timeout_wait%0d got %b want %b", i, obs(), ExpDstall);
      end
      step();
    end
    mem_req = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== ExpTrap) begin
      errors++; $display("FAIL trap_pulse got %b want %b", obs(), ExpTrap);
    end
    step();
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL trap_to_run got %b want %b", obs(), ExpRun);
    end
    step();
  endtask

  task automatic test_limit_completion();
    mem_req = 1'b1; dmem_ready = 1'b0;
    step();
    step();
    step();
    dmem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL limit_complete got %b want %b", obs(), ExpRun);
    end
    step();
    set_idle();
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL limit_no_trap got %b want %b", obs(), ExpRun);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    mem_req = 1'b1; dmem_ready = 1'b0;
    step();
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (obs() !== ExpInit) begin
      errors++; $display("FAIL async_abort got %b want %b", obs(), ExpInit);
    end
    step();
    set_idle();
    nrst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== ExpInit) begin
        errors++; $display("FAIL reinit_cycle%0d got %b want %b", i, obs(), ExpInit);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (obs() !== ExpRun) begin
      errors++; $display("FAIL reinit_run got %b want %b", obs(), ExpRun);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_dmem_wait();
    test_timeout();
    test_limit_completion();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
